// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default depth,
// wait-counter width and strobe-width helper.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int unsigned DMEM_DEPTH_DEFAULT = 1024;
    localparam int unsigned DMEM_LAT_CNT_W     = 4;

    function automatic int unsigned dmem_strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled synchronous single-port word RAM with a registered read port.
// The read register loads the addressed word on a read access and clears on any other access.
module dmem_ram
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = DMEM_DEPTH_DEFAULT,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned STRB_W = dmem_strb_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         rdata <= '0;
        else if (acc_en) rdata <= rd_en ? mem[idx] : '0;
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request slave with a programmable wait before the response.
// Define DMEM_MISALIGN_CHK_EN to flag accesses with addr[1:0] != 0 as errors.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
    input  logic [dmem_strb_w(DATA_W)-1:0] req_wstrb,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned STRB_W   = dmem_strb_w(DATA_W);
    localparam logic        ZERO_LAT = (LATENCY == 0);

    dmem_state_e               state;
    logic [DMEM_LAT_CNT_W-1:0] cnt;
    logic                      lat_we;
    logic [ADDR_W-1:0]         lat_addr;
    logic [DATA_W-1:0]         lat_wdata;
    logic [STRB_W-1:0]         lat_wstrb;

    logic                      hs_c, access_c, err_c, oor_c, mis_c;
    logic                      sel_we;
    logic [ADDR_W-1:0]         sel_addr;
    logic [DATA_W-1:0]         sel_wdata;
    logic [STRB_W-1:0]         sel_wstrb;

    // With zero latency the access happens on the accept edge, straight from the request bus.
    always_comb begin
        sel_we    = lat_we;
        sel_addr  = lat_addr;
        sel_wdata = lat_wdata;
        sel_wstrb = lat_wstrb;
        if (state == DMEM_IDLE) begin
            sel_we    = req_we;
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
            sel_wstrb = req_wstrb;
        end
    end

    assign hs_c     = (state == DMEM_IDLE) && req_valid && req_ready;
    assign access_c = ZERO_LAT ? hs_c : ((state == DMEM_WAIT) && (cnt == '0));

    if (ADDR_W > IDX_W + 2) begin : g_oor
        assign oor_c = |sel_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
        assign oor_c = 1'b0;
    end

`ifdef DMEM_MISALIGN_CHK_EN
    assign mis_c = |sel_addr[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^sel_addr[1:0];
    assign mis_c           = 1'b0;
`endif

    assign err_c = oor_c || mis_c;

    // Reset on the access edge suppresses the write so a dropped store leaves no trace.
    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst_n),
        .acc_en (access_c),
        .wr_en  (access_c && sel_we && !err_c && !rst_n),
        .rd_en  (!sel_we && !err_c),
        .idx    (sel_addr[IDX_W+1:2]),
        .wdata  (sel_wdata),
        .wstrb  (sel_wstrb),
        .rdata  (rsp_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    req_ready <= 1'b1;
                    if (hs_c) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        req_ready <= 1'b0;
                        if (ZERO_LAT) begin
                            state     <= DMEM_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err_c;
                        end else begin
                            cnt   <= DMEM_LAT_CNT_W'(LATENCY - 1);
                            state <= DMEM_WAIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (cnt == '0) begin
                        state     <= DMEM_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_c;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DMEM_RESP: begin
                    if (rsp_ready) begin
                        state     <= DMEM_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= DMEM_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomised bench for dmem_resp: three responders (LATENCY 0, 1, 3) checked against a
// word-array reference model built from the access rules.
module tb_dmem_resp;

    localparam int unsigned NI = 3;
    localparam int unsigned NW = 16;

    logic        clk;
    logic        rst;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_wstrb [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    logic [31:0] ref_mem [NI][NW];
    int          n_tests = 0;
    int          n_fail  = 0;

    for (genvar g = 0; g < int'(NI); g++) begin : g_dut
        dmem_resp #(
            .DATA_W  (32),
            .ADDR_W  (32),
            .DEPTH   (1024),
            .LATENCY ((g == 2) ? 3 : g)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    // One full transaction: issue, check latency/data/error, hold under back-pressure, release.
    task automatic do_txn(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int hold, output logic [31:0] got);
        bit          ok;
        bit          exp_err;
        int          w;
        int          k;
        logic [31:0] exp_rd;
        got     = 'x;
        w       = int'((addr >> 2) & 32'h3FF);
        exp_err = (addr >= 32'h1000);
`ifdef DMEM_MISALIGN_CHK_EN
        if (addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
        exp_rd = (we || exp_err) ? 32'h0 : ref_mem[i][w];
        wait_ready(i, ok);
        if (!ok) return;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wstrb[i] = wstrb;
        @(posedge clk);
        @(negedge clk);
        req_valid[i] = 1'b0;
        k = 0;
        while (rsp_valid[i] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (rsp_valid[i] !== 1'b1) begin
            chk("rsp_valid_timeout", 32'd0, 32'd1);
            return;
        end
        chk($sformatf("lat i%0d", i), 32'(k), 32'(lat_of(i)));
        chk($sformatf("err i%0d a%h", i, addr), 32'(rsp_err[i]), 32'(exp_err));
        chk($sformatf("rdata i%0d a%h", i, addr), rsp_rdata[i], exp_rd);
        got = rsp_rdata[i];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid[i]), 32'd1);
            chk("hold_rdata", rsp_rdata[i], exp_rd);
            chk("hold_req_ready", 32'(req_ready[i]), 32'd0);
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        chk("post_valid", 32'(rsp_valid[i]), 32'd0);
        chk("post_req_ready", 32'(req_ready[i]), 32'd1);
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) ref_mem[i][w][b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    endtask

    task automatic chk_reset_outs(input int i);
        chk($sformatf("rst_req_ready i%0d", i), 32'(req_ready[i]), 32'd0);
        chk($sformatf("rst_rsp_valid i%0d", i), 32'(rsp_valid[i]), 32'd0);
        chk($sformatf("rst_rsp_err i%0d", i), 32'(rsp_err[i]), 32'd0);
        chk($sformatf("rst_rsp_rdata i%0d", i), rsp_rdata[i], 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        bit          ok;
        int          i;
        int          mode;

        rst = 1'b1;
        for (int j = 0; j < int'(NI); j++) begin
            req_valid[j] = 1'b0;
            req_we[j]    = 1'b0;
            req_addr[j]  = '0;
            req_wdata[j] = '0;
            req_wstrb[j] = '0;
            rsp_ready[j] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < int'(NI); j++) chk_reset_outs(j);
        rst = 1'b0;

        // Preload the modelled words so every later load has a known value.
        for (int j = 0; j < int'(NI); j++) begin
            for (int w = 0; w < int'(NW); w++) begin
                do_txn(j, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, got);
            end
        end

        do_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
        do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        chk("roundtrip", got, 32'hDEADBEEF);
        do_txn(1, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1, got);
        do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 5, got);
        chk("byte_strobe", got, 32'hDE22BE44);
        do_txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'h0, 0, got);
        do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
        chk("zero_strobe", got, 32'hDE22BE44);

        do_txn(1, 1'b0, 32'h1000, 32'h0, 4'h0, 0, got);
        do_txn(1, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 0, got);
        do_txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, got);

        do_txn(0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 0, got);
        do_txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 2, got);
        do_txn(0, 1'b1, 32'h11, 32'h77777777, 4'hF, 0, got);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);

        // Store accepted into WAIT, then reset: the store must never land.
        wait_ready(2, ok);
        if (ok) begin
            req_valid[2] = 1'b1;
            req_we[2]    = 1'b1;
            req_addr[2]  = 32'h10;
            req_wdata[2] = ~ref_mem[2][4];
            req_wstrb[2] = 4'hF;
            @(posedge clk);
            @(negedge clk);
            req_valid[2] = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            chk_reset_outs(2);
            repeat (4) @(negedge clk);
            chk("rst_wait_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        do_txn(2, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);

        // Reset on the same edge as a zero-latency store handshake.
        wait_ready(0, ok);
        if (ok) begin
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 32'h14;
            req_wdata[0] = ~ref_mem[0][5];
            req_wstrb[0] = 4'hF;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            req_valid[0] = 1'b0;
            rst = 1'b0;
            chk_reset_outs(0);
        end
        do_txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, got);

        for (int n = 0; n < 150; n++) begin
            i    = int'($urandom_range(NI - 1, 0));
            mode = int'($urandom_range(9, 0));
            if (mode == 0)      addr = 32'h1000 + ($urandom_range(255, 0) << 2);
            else if (mode == 1) addr = ($urandom_range(NW - 1, 0) << 2) | $urandom_range(3, 1);
            else if (mode == 2) addr = 32'hFFFF_0000 | ($urandom_range(NW - 1, 0) << 2);
            else                addr = $urandom_range(NW - 1, 0) << 2;
            do_txn(i, 1'($urandom_range(1, 0)), addr, $urandom, 4'($urandom_range(15, 0)),
                   int'($urandom_range(3, 0)), got);
        end

        for (int j = 0; j < int'(NI); j++) begin
            for (int w = 0; w < int'(NW); w++) begin
                do_txn(j, 1'b0, 32'(w * 4), 32'h0, 4'h0, 0, got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
